// File: rtl/axil_cmd_initiator.sv
// Single-outstanding command/response front end that issues one AXI-Lite write
// (AW/W/B) or read (AR/R) per command, with a watchdog for hung consumers.
module axil_cmd_initiator #(
    parameter int                AW       = 32,
    parameter int                DW       = 32,
    parameter int                STRB     = 4,
    parameter int                PROTW    = 3,
    parameter int                RESPLEN  = 2,
    parameter logic [PROTW-1:0]  PROT_VAL = '0,
    parameter int                TMO_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [TMO_W-1:0]   tmo_limit,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [AW-1:0]      cmd_addr,
    input  logic [DW-1:0]      cmd_wdata,
    input  logic [STRB-1:0]    cmd_wstrb,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DW-1:0]      rsp_rdata,
    output logic [RESPLEN-1:0] rsp_resp,
    output logic               rsp_timeout,
    output logic [AW-1:0]      awaddr,
    output logic [PROTW-1:0]   awprot,
    output logic               awvalid,
    input  logic               awready,
    output logic [DW-1:0]      wdata,
    output logic [STRB-1:0]    wstrb,
    output logic               wvalid,
    input  logic               wready,
    input  logic [RESPLEN-1:0] bresp,
    input  logic               bvalid,
    output logic               bready,
    output logic [AW-1:0]      araddr,
    output logic [PROTW-1:0]   arprot,
    output logic               arvalid,
    input  logic               arready,
    input  logic [DW-1:0]      rdata,
    input  logic [RESPLEN-1:0] rresp,
    input  logic               rvalid,
    output logic               rready
);

    localparam logic [RESPLEN-1:0] TMO_RESP = RESPLEN'(2);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RESP} state_t;

    state_t             state_q;
    logic [AW-1:0]      addr_q;
    logic [DW-1:0]      wdata_q;
    logic [STRB-1:0]    wstrb_q;
    logic               aw_done_q;
    logic               w_done_q;
    logic [TMO_W-1:0]   cnt_q;
    logic [DW-1:0]      rdata_q;
    logic [RESPLEN-1:0] resp_q;
    logic               timeout_q;

    logic busy;
    logic tmo_hit;
    logic aw_done_d;
    logic w_done_d;

    assign busy      = (state_q == WADDR) || (state_q == WRESP) ||
                       (state_q == RADDR) || (state_q == RDATA);
    // >= rather than == so an intermediate handshake (AR) landing on the expiry
    // cycle cannot step the counter past the compare point.
    assign tmo_hit   = (tmo_limit != '0) && (cnt_q >= tmo_limit - TMO_W'(1));
    assign aw_done_d = aw_done_q | awready;
    assign w_done_d  = w_done_q | wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (busy && (cnt_q != '1))
                cnt_q <= cnt_q + TMO_W'(1);

            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        wstrb_q   <= cmd_wstrb;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        cnt_q     <= '0;
                        rdata_q   <= '0;
                        resp_q    <= '0;
                        timeout_q <= 1'b0;
                        state_q   <= cmd_write ? WADDR : RADDR;
                    end
                end
                WADDR: begin
                    if (aw_done_d && w_done_d) begin
                        state_q <= WRESP;
                    end else if (tmo_hit) begin
                        resp_q    <= TMO_RESP;
                        timeout_q <= 1'b1;
                        state_q   <= RESP;
                    end else begin
                        aw_done_q <= aw_done_d;
                        w_done_q  <= w_done_d;
                    end
                end
                WRESP: begin
                    if (bvalid) begin
                        resp_q  <= bresp;
                        rdata_q <= '0;
                        state_q <= RESP;
                    end else if (tmo_hit) begin
                        resp_q    <= TMO_RESP;
                        timeout_q <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                RADDR: begin
                    if (arready) begin
                        state_q <= RDATA;
                    end else if (tmo_hit) begin
                        resp_q    <= TMO_RESP;
                        timeout_q <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                RDATA: begin
                    if (rvalid) begin
                        rdata_q <= rdata;
                        resp_q  <= rresp;
                        state_q <= RESP;
                    end else if (tmo_hit) begin
                        resp_q    <= TMO_RESP;
                        timeout_q <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;
    assign rsp_timeout = timeout_q;

    assign awaddr  = addr_q;
    assign awprot  = PROT_VAL;
    assign awvalid = (state_q == WADDR) && !aw_done_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wvalid  = (state_q == WADDR) && !w_done_q;
    assign bready  = (state_q == WRESP);
    assign araddr  = addr_q;
    assign arprot  = PROT_VAL;
    assign arvalid = (state_q == RADDR);
    assign rready  = (state_q == RDATA);

endmodule

// File: tb/tb_axil_cmd_initiator.sv
// Bench for axil_cmd_initiator: directed handshake/timeout/reset cases, then a
// randomized back-to-back write/read run against a memory-level reference.
module tb_axil_cmd_initiator;

    logic        clk, rst;
    logic [15:0] tmo_limit;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    axil_cmd_initiator dut (
        .clk(clk), .rst(rst), .tmo_limit(tmo_limit),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_in();
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    endtask

    // Presents one command in IDLE; returns at the negedge of the first busy cycle.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
        tick();
        cmd_valid = 0;
    endtask

    task automatic pop_rsp();
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
    endtask

    // Reference-level rules for the random run
    function automatic logic [1:0] resp_of(input logic [31:0] a);
        return a[5:4];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_ref[16];
    logic [31:0] mem_slv[16];
    logic        c_wr[16];
    logic [31:0] c_a[16], c_d[16];
    logic [3:0]  c_s[16];

    initial begin
        int wbeats, busy_cyc, k, nrsp, n_aw, n_w;
        logic saw_rsp, adv;
        logic have_aw, have_w, b_on, ar_on, r_on;
        logic [31:0] aw_a, w_d, ar_a;
        logic [3:0]  w_s;
        exp_t e;

        idle_in();
        tmo_limit = 0;
        rst = 1;
        tick(); tick();
        chk_eq("reset_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout}, 0);
        chk_eq("reset_cmd_ready", cmd_ready, 1);
        chk_eq("reset_payload", {rsp_rdata, rsp_resp, awaddr[15:0]}, 0);
        rst = 0;
        tick();

        // zero-latency write
        issue(1, 32'h10, 32'hA5A5_0001, 4'hF);
        chk_eq("t1_aw_w_valid", {awvalid, wvalid, rsp_valid}, 3'b110);
        chk_eq("t1_payload", {awaddr, wdata, wstrb, awprot}, {32'h10, 32'hA5A5_0001, 4'hF, 3'b000});
        awready = 1; wready = 1;
        tick();
        awready = 0; wready = 0;
        chk_eq("t1_valids_1cyc", {awvalid, wvalid, bready, rsp_valid}, 4'b0010);
        bvalid = 1; bresp = 0;
        tick();
        bvalid = 0;
        chk_eq("t1_rsp", {rsp_valid, rsp_timeout, rsp_resp, bready, cmd_ready}, {1'b1, 1'b0, 2'b00, 1'b0, 1'b0});
        chk_eq("t1_rdata", rsp_rdata, 0);
        pop_rsp();
        chk_eq("t1_idle", {cmd_ready, rsp_valid}, 2'b10);

        // split write handshake: W accepted 4 cycles before AW
        issue(1, 32'h20, 32'h1234_5678, 4'h3);
        wbeats = 0;
        for (int i = 0; i < 5; i++) begin
            chk_eq("t2_aw_hold", {awvalid, awaddr}, {1'b1, 32'h20});
            wready = 1; awready = (i == 4);
            if (wvalid) wbeats++;
            tick();
        end
        awready = 0; wready = 0;
        chk_eq("t2_w_beats", wbeats, 1);
        chk_eq("t2_in_wresp", {awvalid, wvalid, bready}, 3'b001);
        bvalid = 1; bresp = 2'b01;
        tick();
        bvalid = 0;
        chk_eq("t2_rsp", {rsp_valid, rsp_resp, rsp_timeout}, {1'b1, 2'b01, 1'b0});
        pop_rsp();
        chk_eq("t2_single_rsp", rsp_valid, 0);

        // read with AR and response backpressure
        issue(0, 32'h04, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk_eq("t3_ar_hold", {arvalid, araddr}, {1'b1, 32'h04});
            arready = (i == 3);
            tick();
        end
        arready = 0;
        chk_eq("t3_rready", {arvalid, rready}, 2'b01);
        rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
        tick();
        rvalid = 0; rdata = 0; rresp = 0;
        for (int i = 0; i < 5; i++) begin
            chk_eq("t3_rsp_held", {rsp_valid, cmd_ready, rsp_rdata, rsp_resp, rsp_timeout},
                   {1'b1, 1'b0, 32'hDEAD_BEEF, 2'b10, 1'b0});
            tick();
        end
        pop_rsp();
        chk_eq("t3_idle", cmd_ready, 1);

        // watchdog expiry on a write with no B response
        tmo_limit = 8;
        issue(1, 32'h30, 32'h5555_AAAA, 4'hF);
        awready = 1; wready = 1;
        busy_cyc = 0;
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            if (awvalid || wvalid || bready) busy_cyc++;
            tick();
        end
        awready = 0; wready = 0;
        chk_eq("t4_busy_cycles", busy_cyc, 8);
        chk_eq("t4_tmo_rsp", {rsp_valid, bready, rsp_timeout, rsp_resp, rsp_rdata},
               {1'b1, 1'b0, 1'b1, 2'b10, 32'h0});
        pop_rsp();
        issue(0, 32'h08, 0, 0);
        arready = 1;
        tick();
        arready = 0; rvalid = 1; rdata = 32'h0BAD_F00D; rresp = 2'b00;
        tick();
        rvalid = 0;
        chk_eq("t4_next_normal", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata},
               {1'b1, 1'b0, 2'b00, 32'h0BAD_F00D});
        pop_rsp();

        // rvalid arriving in the very cycle the watchdog expires
        tmo_limit = 4;
        issue(0, 32'h0C, 0, 0);
        arready = 1;
        tick();
        arready = 0;
        tick(); tick();
        rvalid = 1; rdata = 32'hCAFE_0001; rresp = 2'b01;
        tick();
        rvalid = 0;
        chk_eq("t4_expiry_hs_wins", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata},
               {1'b1, 1'b0, 2'b01, 32'hCAFE_0001});
        pop_rsp();

        // reset in the middle of a read
        tmo_limit = 0;
        issue(0, 32'h14, 0, 0);
        arready = 1;
        tick();
        arready = 0;
        chk_eq("t5_in_rdata", rready, 1);
        rst = 1;
        #1;
        chk_eq("t5_rst_drop", {arvalid, rready, rsp_valid, cmd_ready}, 4'b0001);
        tick();
        rvalid = 1; rdata = 32'h7777_7777;
        rst = 0;
        tick();
        rvalid = 0;
        saw_rsp = 0;
        for (int i = 0; i < 5; i++) begin
            saw_rsp |= rsp_valid;
            tick();
        end
        chk_eq("t5_no_stale_rsp", {saw_rsp, cmd_ready}, 2'b01);

        // randomized back-to-back write/read pairs
        for (int i = 0; i < 16; i++) begin
            mem_ref[i] = 0;
            mem_slv[i] = 0;
        end
        for (int i = 0; i < 16; i += 2) begin
            c_wr[i] = 1;
            c_a[i] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            c_d[i] = $urandom;
            c_s[i] = 4'($urandom_range(1, 15));
            c_wr[i+1] = 0; c_a[i+1] = c_a[i]; c_d[i+1] = 0; c_s[i+1] = 0;
        end
        k = 0; adv = 0; nrsp = 0; n_aw = 0; n_w = 0;
        have_aw = 0; have_w = 0; b_on = 0; ar_on = 0; r_on = 0;
        aw_a = 0; w_d = 0; w_s = 0; ar_a = 0;
        cmd_write = c_wr[0]; cmd_addr = c_a[0]; cmd_wdata = c_d[0]; cmd_wstrb = c_s[0];
        cmd_valid = 1;
        for (int cyc = 0; cyc < 3000 && nrsp < 16; cyc++) begin
            if (adv) begin
                k++;
                adv = 0;
                if (k < 16) begin
                    cmd_write = c_wr[k]; cmd_addr = c_a[k]; cmd_wdata = c_d[k]; cmd_wstrb = c_s[k];
                end else begin
                    cmd_valid = 0;
                end
            end
            if (cmd_valid && cmd_ready) begin
                if (cmd_write) begin
                    mem_ref[cmd_addr[5:2]] = merge(mem_ref[cmd_addr[5:2]], cmd_wdata, cmd_wstrb);
                    e.d = 0;
                end else begin
                    e.d = mem_ref[cmd_addr[5:2]];
                end
                e.r = resp_of(cmd_addr);
                exp_q.push_back(e);
                adv = 1;
            end

            rsp_ready = 1'($urandom_range(0, 1));
            if (rsp_valid && rsp_ready) begin
                nrsp++;
                if (exp_q.size() == 0) begin
                    chk_eq("t6_unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk_eq("t6_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, {e.d, e.r, 1'b0});
                end
            end

            awready = !have_aw && 1'($urandom_range(0, 1));
            if (awvalid && awready) begin
                have_aw = 1; aw_a = awaddr; n_aw++;
            end
            wready = !have_w && 1'($urandom_range(0, 1));
            if (wvalid && wready) begin
                have_w = 1; w_d = wdata; w_s = wstrb; n_w++;
            end
            if (!b_on && have_aw && have_w && 1'($urandom_range(0, 1))) b_on = 1;
            bvalid = b_on;
            bresp = resp_of(aw_a);
            if (b_on && bready) begin
                mem_slv[aw_a[5:2]] = merge(mem_slv[aw_a[5:2]], w_d, w_s);
                have_aw = 0; have_w = 0; b_on = 0;
            end

            arready = !ar_on && 1'($urandom_range(0, 1));
            if (arvalid && arready) begin
                ar_on = 1; ar_a = araddr;
            end
            if (!r_on && ar_on && 1'($urandom_range(0, 1))) r_on = 1;
            rvalid = r_on;
            rdata = r_on ? mem_slv[ar_a[5:2]] : $urandom;
            rresp = resp_of(ar_a);
            if (r_on && rready) begin
                ar_on = 0; r_on = 0;
            end
            tick();
        end
        idle_in();
        chk_eq("t6_rsp_count", nrsp, 16);
        chk_eq("t6_aw_beats", n_aw, 8);
        chk_eq("t6_w_beats", n_w, 8);
        saw_rsp = 0;
        for (int i = 0; i < 10; i++) begin
            saw_rsp |= rsp_valid;
            tick();
        end
        chk_eq("t6_no_extra_rsp", {saw_rsp, cmd_ready}, 2'b01);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/axil_cmd_initiator.md
Name: axil_cmd_initiator

Overview:
- AXI-Lite initiator that drives the CPU-side AXI-Lite port of the SPI 1.0 wrapper, and of any other AXI-Lite consumer, from a simple single-outstanding command/response interface.
- Used by the gyro top-level sequencer and by benches to issue register reads and writes.
- Converts one command into a complete AW/W/B or AR/R transaction.
- A programmable watchdog terminates any transaction whose consumer hangs.

Parameters:
- AW, 32, address width (matches CPU_SPI_AW)
- DW, 32, data width (matches CPU_SPI_DW)
- STRB, 4, write strobe width, DW/8
- PROTW, 3, AxPROT width
- RESPLEN, 2, response width
- PROT_VAL, 3'b000, constant driven on awprot/arprot
- TMO_W, 16, watchdog counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- tmo_limit  in  TMO_W  watchdog limit in cycles; 0 disables the watchdog
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AW  byte address
- cmd_wdata  in  DW  write data
- cmd_wstrb  in  STRB  write strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DW  read data; 0 for writes
- rsp_resp  out  RESPLEN  BRESP/RRESP, or 2'b10 on timeout
- rsp_timeout  out  1  response was produced by the watchdog
- awaddr/awprot/awvalid  out  AW/PROTW/1  AW channel
- awready  in  1
- wdata/wstrb/wvalid  out  DW/STRB/1  W channel
- wready  in  1
- bresp  in  RESPLEN
- bvalid  in  1
- bready  out  1
- araddr/arprot/arvalid  out  AW/PROTW/1  AR channel
- arready  in  1
- rdata  in  DW
- rresp  in  RESPLEN
- rvalid  in  1
- rready  out  1

Behaviour:
- Reset:
  - All outputs are 0 except cmd_ready = 1 (state IDLE).
  - Internal registers and counter are cleared asynchronously.
  - Reset asserted mid-transaction drops all valids immediately.
  - No response is generated for the aborted command.
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, RESP.
- IDLE:
  - cmd_ready = 1.
  - On accept, latch addr, wdata, wstrb and write, and clear the watchdog.
  - The AXI valids assert on the next cycle: 1-cycle command-to-valid latency.
  - write = 1 goes to WADDR; write = 0 goes to RADDR.
- WADDR:
  - awvalid and wvalid assert together.
  - Each valid drops independently in the cycle after its own ready handshake (aw_done/w_done flags).
  - Same-cycle awready and wready completes both.
  - Valids and payloads stay stable until handshake.
  - Leaves for WRESP once both handshakes are done.
- WRESP:
  - bready = 1.
  - On bvalid, capture bresp; rsp_rdata = 0; go to RESP.
- RADDR:
  - arvalid = 1 until arready, then go to RDATA.
- RDATA:
  - rready = 1.
  - On rvalid, capture rdata and rresp; go to RESP.
- RESP:
  - rsp_valid = 1 with held data until rsp_ready, then IDLE.
  - cmd_ready = 0, so the next command is taken earliest one cycle after the rsp handshake.
  - Only one command is outstanding at a time.
- Watchdog:
  - Counter increments every cycle in WADDR/WRESP/RADDR/RDATA; it is held in IDLE and RESP.
  - When tmo_limit != 0 and counter == tmo_limit - 1 with no completing handshake in that cycle:
    - all AXI valids and readies drop the next cycle;
    - rsp_resp = 2'b10, rsp_timeout = 1, rsp_rdata = 0; go to RESP.
  - A handshake in the same cycle as expiry takes priority: normal completion.
  - The counter saturates and never wraps.
- Response codes: bresp/rresp are passed through unmodified (OKAY, EXOKAY, SLVERR, DECERR).

Test Plan:
- Write, zero-latency consumer: cmd write addr 0x10, data 0xA5A5_0001, strb 0xF; awready = wready = 1 and bvalid one cycle later → awvalid/wvalid high exactly 1 cycle, rsp_valid 3 cycles after accept, rsp_resp = 0, rsp_timeout = 0.
- Split write handshake: wready 4 cycles before awready → wvalid drops after its handshake, awvalid held with stable awaddr until awready; single response, no duplicate W beat.
- Read with backpressure: cmd read addr 0x04, arready after 3 cycles, rvalid with rdata 0xDEAD_BEEF and rresp 2'b10; rsp_ready low 5 cycles → rsp held stable, rsp_rdata = 0xDEAD_BEEF, rsp_resp = 2'b10, cmd_ready = 0 throughout.
- Timeout: tmo_limit = 8, consumer never asserts bvalid → exactly 8 cycles in WADDR+WRESP, then bready = 0, rsp_resp = 2'b10, rsp_timeout = 1; next command accepted normally. Also: rvalid in the expiry cycle → normal response.
- Reset mid-read: assert rst while in RDATA → arvalid/rready/rsp_valid = 0 immediately, cmd_ready = 1 after release, no stale response.
- Back-to-back: 16 alternating write/read commands with cmd_valid held high and random readies → read data matches the written data at the same address, one response per command, in order.
